// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if -- request/result bundle for the iterative multiply/divide unit.
//   master (requester): drives start_i, op_i, a_i, b_i, flush_i; observes results.
//   slave  (unit)     : observes requests; drives busy_o, done_o, hi_o, lo_o.
//   start_i  request an operation this cycle
//   op_i     0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a_i/b_i  operands (a_i is also the MTHI/MTLO source)
//   flush_i  abort any operation in flight
//   busy_o   unit occupied, done_o one-cycle result pulse, hi_o/lo_o result registers
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit -- MIPS-style HI/LO multiply/divide unit, one radix-2 step per cycle.
//   clk_i   single clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     mul_div_unit_if.slave (start/op/operands/flush in; busy/done/hi/lo out)
// Signed operations run on operand magnitudes; the result sign is fixed up on the
// final edge, so latency is always WIDTH+1 cycles from acceptance to done_o.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mul_div_unit_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_div_reg;
  logic             neg_q_reg;   // negate product / quotient at the end
  logic             neg_r_reg;   // negate remainder at the end (dividend negative)
  logic [WIDTH-1:0] work_hi_reg; // multiply accumulator / divide partial remainder
  logic [WIDTH-1:0] work_lo_reg; // multiplier bits / dividend bits becoming quotient
  logic [WIDTH-1:0] opnd_reg;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_reg;       // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  // Operand magnitudes at acceptance time
  logic             signed_op;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign signed_op = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
  assign neg_a     = signed_op & bus.a_i[WIDTH-1];
  assign neg_b     = signed_op & bus.b_i[WIDTH-1];
  assign a_mag     = neg_a ? -bus.a_i : bus.a_i;
  assign b_mag     = neg_b ? -bus.b_i : bus.b_i;

  // One iteration
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, opnd_reg} : '0);
  assign rem_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, opnd_reg};
  assign rem_diff  = rem_shift - {1'b0, opnd_reg};

  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (is_div_reg) begin
      // restoring divide: subtract only when it does not go negative
      step_hi = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      step_lo = {work_lo_reg[WIDTH-2:0], rem_ge};
    end else begin
      // shift-add multiply: carry out of the add shifts into the accumulator MSB
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
    end
  end

  // Final result with sign correction, used on the last RUN edge
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_q_reg ? -prod : prod;

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (opnd_reg == '0) begin
        // divide by zero: all-ones quotient, dividend returned unchanged
        res_hi = a_reg;
        res_lo = '1;
      end else begin
        // MIN / -1 falls out naturally: magnitude 2^(W-1) negates to itself
        res_hi = neg_r_reg ? -step_hi : step_hi;
        res_lo = neg_q_reg ? -step_lo : step_lo;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      is_div_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      work_hi_reg <= '0;
      work_lo_reg <= '0;
      opnd_reg    <= '0;
      a_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            case (bus.op_i)
              OP_MULT, OP_MULTU: begin
                state_reg   <= RUN;
                cnt_reg     <= CNT_W'(WIDTH - 1);
                is_div_reg  <= 1'b0;
                neg_q_reg   <= neg_a ^ neg_b;
                neg_r_reg   <= 1'b0;
                work_hi_reg <= '0;
                work_lo_reg <= b_mag;
                opnd_reg    <= a_mag;
                a_reg       <= bus.a_i;
              end
              OP_DIV, OP_DIVU: begin
                state_reg   <= RUN;
                cnt_reg     <= CNT_W'(WIDTH - 1);
                is_div_reg  <= 1'b1;
                neg_q_reg   <= neg_a ^ neg_b;
                neg_r_reg   <= neg_a;
                work_hi_reg <= '0;
                work_lo_reg <= a_mag;
                opnd_reg    <= b_mag;
                a_reg       <= bus.a_i;
              end
              OP_MTHI: hi_reg <= bus.a_i;
              OP_MTLO: lo_reg <= bus.a_i;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (bus.flush_i) begin
            state_reg <= IDLE;
          end else begin
            work_hi_reg <= step_hi;
            work_lo_reg <= step_lo;
            cnt_reg     <= cnt_reg - CNT_W'(1);
            if (cnt_reg == '0) begin
              state_reg <= DONE;
              hi_reg    <= res_hi;
              lo_reg    <= res_lo;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = (state_reg != IDLE);
  assign bus.done_o = (state_reg == DONE);
  assign bus.hi_o   = hi_reg;
  assign bus.lo_o   = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
    string        name;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        p = 64'(sa * sbv);
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd2: begin
        if (b == 0) begin
          hi = a;
          lo = '1;
        end else begin
          sa = longint'($signed(a));
          sbv = longint'($signed(b));
          q = sa / sbv;
          r = sa % sbv;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      3'd3: begin
        if (b == 0) begin
          hi = a;
          lo = '1;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT pulses done_o
  always @(negedge clk) begin
    if (rst_n && bus.done_o === 1'b1) begin : mon
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done_o=1 at cycle %0d, expected no pulse", cycle_cnt);
      end else begin
        e = sb.pop_front();
        $display("txn %s hi=%h lo=%h cycle=%0d", e.name, bus.hi_o, bus.lo_o, cycle_cnt);
        check({e.name, " hi"}, 64'(bus.hi_o), 64'(e.hi));
        check({e.name, " lo"}, 64'(bus.lo_o), 64'(e.lo));
        check({e.name, " latency"}, 64'(cycle_cnt), 64'(e.due));
      end
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Issue a multiply/divide and hold the bench for its full duration.
  // noise=1 keeps start_i asserted with a MULT while the unit is busy.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [W-1:0] eh, el;
    string nm;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i = op;
    bus.a_i = a;
    bus.b_i = b;
    model(op, a, b, eh, el);
    nm = $sformatf("op%0d a=%h b=%h", op, a, b);
    sb.push_back('{hi: eh, lo: el, due: cycle_cnt + W + 1, name: nm});
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk); #1;
      bus.start_i = noise;
      bus.op_i = 3'd0;
      bus.a_i = W'($urandom);
      bus.b_i = W'($urandom);
      if (k == 1 || k == W + 1) check({nm, " busy"}, 64'(bus.busy_o), 64'd1);
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    m_hi = eh;
    m_lo = el;
    check({nm, " done_seen"}, 64'(sb.size()), 64'd0);
    check({nm, " idle"}, 64'(bus.busy_o), 64'd0);
    check({nm, " hi_hold"}, 64'(bus.hi_o), 64'(m_hi));
  endtask

  // Single-cycle request (MTHI/MTLO/no-op), optionally dropped by flush_i
  task automatic do_move(input logic [2:0] op, input logic [W-1:0] a, input bit flush);
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i = op;
    bus.a_i = a;
    bus.flush_i = flush;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    if (!flush && op == 3'd4) m_hi = a;
    if (!flush && op == 3'd5) m_lo = a;
    $display("txn move op%0d a=%h flush=%0d hi=%h lo=%h", op, a, flush, bus.hi_o, bus.lo_o);
    check($sformatf("move op%0d hi", op), 64'(bus.hi_o), 64'(m_hi));
    check($sformatf("move op%0d lo", op), 64'(bus.lo_o), 64'(m_lo));
    check($sformatf("move op%0d busy", op), 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    int c;
    logic [2:0] rop;
    bus.start_i = 1'b0;
    bus.op_i = '0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.flush_i = 1'b0;

    // Reset state
    #12;
    check("reset busy", 64'(bus.busy_o), 64'd0);
    check("reset done", 64'(bus.done_o), 64'd0);
    check("reset hi", 64'(bus.hi_o), 64'd0);
    check("reset lo", 64'(bus.lo_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed results
    do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd3, 32'd100, 32'd7, 1'b0);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd3, 32'h0000_1234, 32'd0, 1'b0);
    do_op(3'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
    // Start reasserted while busy is ignored
    do_op(3'd3, 32'd1000, 32'd33, 1'b1);

    // Moves, no-ops and flush-with-start
    do_move(3'd4, 32'h1357_9BDF, 1'b0);
    do_move(3'd5, 32'h2468_ACE0, 1'b0);
    do_move(3'd6, 32'hDEAD_BEEF, 1'b0);
    do_move(3'd7, 32'hDEAD_BEEF, 1'b0);
    do_move(3'd4, 32'hCAFE_F00D, 1'b1);
    do_move(3'd5, 32'hCAFE_F00D, 1'b1);

    // Flush in RUN
    do_move(3'd4, 32'hA5A5_A5A5, 1'b0);
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i = 3'd0;
    bus.a_i = 32'd2;
    bus.b_i = 32'd3;
    c = cycle_cnt;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    while (cycle_cnt < c + 10) begin
      @(posedge clk); #1;
    end
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    $display("txn flush busy=%0d hi=%h lo=%h", bus.busy_o, bus.hi_o, bus.lo_o);
    check("flush busy", 64'(bus.busy_o), 64'd0);
    check("flush hi", 64'(bus.hi_o), 64'hA5A5_A5A5);
    check("flush lo", 64'(bus.lo_o), 64'(m_lo));
    repeat (W + 4) @(posedge clk);
    #1;
    check("flush hi_after", 64'(bus.hi_o), 64'hA5A5_A5A5);

    // Asynchronous reset mid-RUN
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i = 3'd1;
    bus.a_i = 32'h1234_5678;
    bus.b_i = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    $display("txn async_reset busy=%0d hi=%h lo=%h", bus.busy_o, bus.hi_o, bus.lo_o);
    check("areset busy", 64'(bus.busy_o), 64'd0);
    check("areset done", 64'(bus.done_o), 64'd0);
    check("areset hi", 64'(bus.hi_o), 64'd0);
    check("areset lo", 64'(bus.lo_o), 64'd0);
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      do_op(rop, pick(), pick(), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
